vendor_input_cond: RTL
======================

Name: vendor_input_cond

Overview:
Input conditioner directly upstream of the vending-machine FSM (vendor). It takes three raw, asynchronous, bouncing push-button/coin-sensor lines (coin c, coin f, purchase p). It synchronises and debounces each line, then turns each debounced press into a single-cycle, one-hot pulse on c/f/p. When several presses are pending, it serialises them so vendor never sees two inputs in the same cycle.

Parameters:
DEB_CYCLES, 4, consecutive synchronised cycles a level must hold before it is accepted (legal range >= 1)
CNT_W, $clog2(DEB_CYCLES+1), debounce counter width (derived; do not override)

Ports:
clk  in  1  system clock; all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
btn_c  in  1  raw coin-c line, asynchronous, active high
btn_f  in  1  raw coin-f line, asynchronous, active high
btn_p  in  1  raw purchase line, asynchronous, active high
en  in  1  1 = vendor may accept an event this cycle; 0 = hold pending events
c  out  1  one-cycle pulse to vendor.c
f  out  1  one-cycle pulse to vendor.f
p  out  1  one-cycle pulse to vendor.p
drop_err  out  1  sticky flag: a press was lost because the same channel was already pending

Behaviour:
- Reset (reset=0, asynchronous): c=f=p=0, drop_err=0. All sync flops, debounce counters, stable levels and pending bits are 0. Reset takes effect immediately, even mid-count or with events pending; nothing pending before reset is issued afterwards.
- Per channel (x in c,f,p), identical logic:
  - Sync: two-flop synchroniser, s_x = second stage.
  - Debounce: stable level q_x and counter cnt_x.
    - If s_x == q_x, cnt_x <= 0.
    - Otherwise cnt_x increments. On the edge where it would reach DEB_CYCLES, q_x <= s_x and cnt_x <= 0.
    - Any mismatch gap restarts the count from 0.
  - Edge detect: the edge that moves q_x from 0 to 1 sets pend_x. A 1->0 transition produces no event but still needs DEB_CYCLES stable-low cycles before a new press can register.
  - Overflow: if pend_x is already 1 when a new rise occurs, and pend_x is not being cleared on that same edge, the press is dropped and drop_err <= 1. drop_err stays 1 until reset.
- Arbiter/output register (registered outputs):
  - Each edge with en=1 and any pend set: exactly one output pulses next cycle, chosen by fixed priority c > f > p (credit before purchase). The chosen pend bit is cleared on the same edge.
  - en=0: no output pulses, pend bits are held.
  - A pend bit set on edge N is eligible for issue on edge N+1.
- Latency: raw line first sampled high on edge 1 and held clean -> output high during the cycle after edge DEB_CYCLES+3. With DEB_CYCLES=4 that is edge 7. This assumes en=1 and no higher-priority pend.
- Invariants:
  - c+f+p <= 1 in every cycle.
  - Each output pulse is exactly one cycle wide.
  - One accepted press yields exactly one pulse.
- Simultaneous rises on all three channels on the same edge issue on three consecutive cycles in the order c, f, p.

Decomposition:
- Shared package vendor_pkg holds:
  - channel index constants CH_C=0, CH_F=1, CH_P=2;
  - NUM_CH=3;
  - the default DEB_CYCLES, so vendor and the bench agree on timing.
- Sub-module debounce_ch contains sync + counter + stable level + rise pulse and is instantiated three times.
- The arbiter and pend/drop_err logic stay in vendor_input_cond.

Test Plan:
- Reset: hold reset=0 and toggle all btn_* for 20 cycles -> c=f=p=0 and drop_err=0 throughout. Release reset -> still 0 with buttons idle.
- Clean press, DEB_CYCLES=4, en=1: btn_c high from edge 1 for 10 cycles -> c=1 only in the cycle after edge 7; f=p=0. Holding btn_c longer produces no second pulse.
- Bounce on btn_f: pattern high 2 cycles, low 1, high 3, low 5 -> no pulse. Then high for 6 cycles -> exactly one f pulse, 7 edges after that final rise.
- Simultaneous press: btn_c, btn_f, btn_p rise on the same edge -> c, f, p pulse on three consecutive cycles in that order, never overlapping.
- Backpressure: en=0, press btn_p once (held 8 cycles) -> no pulse while en=0. Raise en -> one p pulse the cycle after the first en=1 edge. Repeat with two separate debounced presses while en=0 -> drop_err=1 and still exactly one p pulse.
- Reset mid-operation: pend_c set and en=0, then pulse reset low for 1 cycle -> outputs 0 immediately; after reset release and en=1, no c pulse appears.

Source files
------------

// File: rtl/vendor_pkg.sv
// vendor_pkg: channel indices, channel count and default debounce length shared by vendor, its conditioner and benches
package vendor_pkg;
    localparam int CH_C = 0;
    localparam int CH_F = 1;
    localparam int CH_P = 2;
    localparam int NUM_CH = 3;
    localparam int DEB_CYCLES_DEF = 4;
    // Lowest-index set bit wins, so coin c beats coin f beats purchase p.
    function automatic logic [NUM_CH-1:0] prio_grant(input logic [NUM_CH-1:0] req);
        return req & (~req + NUM_CH'(1));
    endfunction
endpackage

// File: rtl/vendor_input_cond_if.sv
// vendor_input_cond_if: raw button lines and enable in, one-hot event pulses and sticky drop flag out
interface vendor_input_cond_if;
    logic btn_c, btn_f, btn_p, en;
    logic c, f, p, drop_err;
    modport master (output btn_c, btn_f, btn_p, en, input c, f, p, drop_err);
    modport slave (input btn_c, btn_f, btn_p, en, output c, f, p, drop_err);
endinterface

// File: rtl/debounce_ch.sv
// debounce_ch: two-flop synchroniser, debounce counter and stable level; rise_o marks the edge on which the level goes 0->1
module debounce_ch #(
    parameter int DEB_CYCLES = vendor_pkg::DEB_CYCLES_DEF,
    localparam int CNT_W = $clog2(DEB_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic rise_o
);
    logic [1:0] sync_q;
    logic lvl_q, lvl_d, flip;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_comb begin
        flip = (sync_q[1] != lvl_q) && (cnt_q == CNT_W'(DEB_CYCLES - 1));
        cnt_d = (sync_q[1] == lvl_q || flip) ? '0 : cnt_q + CNT_W'(1);
        lvl_d = flip ? sync_q[1] : lvl_q;
        rise_o = flip && sync_q[1];
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            cnt_q <= '0;
            lvl_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], raw_i};
            cnt_q <= cnt_d;
            lvl_q <= lvl_d;
        end
    end
endmodule

// File: rtl/vendor_input_cond.sv
// vendor_input_cond: debounces the c/f/p lines and serialises accepted presses into one-hot single-cycle pulses for vendor
module vendor_input_cond
    import vendor_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input logic clk,
    input logic reset,
    vendor_input_cond_if.slave bus
);
    logic [NUM_CH-1:0] raw, rise, gnt, pend_q, pend_d, out_q;
    logic drop_q, drop_d;
    assign raw[CH_C] = bus.btn_c;
    assign raw[CH_F] = bus.btn_f;
    assign raw[CH_P] = bus.btn_p;
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_ch #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk(clk),
            .reset(reset),
            .raw_i(raw[i]),
            .rise_o(rise[i])
        );
    end
    // A rise only overflows when its pend bit stays set through this edge.
    always_comb begin
        gnt = bus.en ? prio_grant(pend_q) : '0;
        pend_d = (pend_q & ~gnt) | rise;
        drop_d = drop_q | (|(rise & pend_q & ~gnt));
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q <= '0;
            out_q <= '0;
            drop_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            out_q <= gnt;
            drop_q <= drop_d;
        end
    end
    assign bus.c = out_q[CH_C];
    assign bus.f = out_q[CH_F];
    assign bus.p = out_q[CH_P];
    assign bus.drop_err = drop_q;
endmodule
